// File: rtl/latency_sink_pkg.sv
// latency_sink_pkg: default depth and credit/pointer width helpers shared by latency_sink and sink_ram
package latency_sink_pkg;
  localparam int LS_DEPTH = 8;
  function automatic int credit_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/sink_ram.sv
// sink_ram: unreset storage, one write port (i_we/i_waddr/i_wdata) and one combinational read port (i_raddr/o_rdata)
module sink_ram
  import latency_sink_pkg::*;
#(
  parameter int PIPE_WIDTH = 1,
  parameter int DEPTH = LS_DEPTH
) (
  input  logic                    clk,
  input  logic                    i_we,
  input  logic [ptr_w(DEPTH)-2:0] i_waddr,
  input  logic [PIPE_WIDTH-1:0]   i_wdata,
  input  logic [ptr_w(DEPTH)-2:0] i_raddr,
  output logic [PIPE_WIDTH-1:0]   o_rdata
);
  logic [PIPE_WIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/latency_sink.sv
// latency_sink: credit-gated FWFT buffer for a fixed-latency pipe; ports issue/can_issue (credits), in_valid/in_data (push), out_valid/out_data/out_ready (pop), sticky overflow/underflow; LATENCY_SINK_STATS_EN adds hwm_occupancy/pop_count
module latency_sink
  import latency_sink_pkg::*;
#(
  parameter int PIPE_WIDTH = 1,
  parameter int DEPTH = LS_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue,
  output logic                  can_issue,
  input  logic                  in_valid,
  input  logic [PIPE_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [PIPE_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  overflow,
  output logic                  underflow
`ifdef LATENCY_SINK_STATS_EN
  ,
  output logic [credit_w(DEPTH)-1:0] hwm_occupancy,
  output logic [31:0]                pop_count
`endif
);
  localparam int CW = credit_w(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  logic [CW-1:0] r_cred;
  logic [PW-1:0] r_wp, r_rp;
  logic r_over, r_under;
  logic w_full, w_empty, w_push, w_pop, w_acc;
  assign w_empty = r_wp == r_rp;
  assign w_full = (r_wp[PW-2:0] == r_rp[PW-2:0]) && (r_wp[PW-1] != r_rp[PW-1]);
  assign w_push = in_valid & ~w_full;
  assign w_pop = ~w_empty & out_ready;
  assign w_acc = issue & can_issue;
  assign can_issue = r_cred != '0;
  assign out_valid = ~w_empty;
  assign overflow = r_over;
  assign underflow = r_under;
  always_ff @(posedge clk)
    if (rst) begin
      r_cred <= CW'(DEPTH);
      r_wp <= '0;
      r_rp <= '0;
      r_over <= 1'b0;
      r_under <= 1'b0;
    end else begin
      r_cred <= r_cred - CW'(w_acc) + CW'(w_pop);
      r_wp <= r_wp + PW'(w_push);
      r_rp <= r_rp + PW'(w_pop);
      r_over <= r_over | (in_valid & w_full);
      r_under <= r_under | (issue & ~can_issue);
    end
  sink_ram #(.PIPE_WIDTH(PIPE_WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk(clk),
    .i_we(w_push & ~rst),
    .i_waddr(r_wp[PW-2:0]),
    .i_wdata(in_data),
    .i_raddr(r_rp[PW-2:0]),
    .o_rdata(out_data)
  );
`ifdef LATENCY_SINK_STATS_EN
  logic [CW-1:0] w_occ;
  assign w_occ = CW'(r_wp - r_rp);
  always_ff @(posedge clk)
    if (rst) begin
      hwm_occupancy <= '0;
      pop_count <= '0;
    end else begin
      hwm_occupancy <= (w_occ > hwm_occupancy) ? w_occ : hwm_occupancy;
      pop_count <= pop_count + 32'(w_pop);
    end
`endif
endmodule

// File: tb/tb_latency_sink.sv
// tb_latency_sink: table-driven directed check of latency_sink at DEPTH=4, PIPE_WIDTH=8
module tb_latency_sink;
  logic clk, rst, issue, can_issue, in_valid, out_valid, out_ready, overflow, underflow;
  logic [7:0] in_data, out_data;
`ifdef LATENCY_SINK_STATS_EN
  logic [2:0] hwm_occupancy;
  logic [31:0] pop_count;
`endif
  int total, bad;
  latency_sink #(.PIPE_WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .issue(issue), .can_issue(can_issue),
    .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .overflow(overflow),
    .underflow(underflow)
`ifdef LATENCY_SINK_STATS_EN
    , .hwm_occupancy(hwm_occupancy), .pop_count(pop_count)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    string nm;
    logic rs, is, iv;
    logic [7:0] d;
    logic rd;
    logic ci, ov;
    logic [7:0] od;
    logic of, uf;
    logic [2:0] cr;
  } vec_t;
  vec_t q[$];
  task automatic v(input string nm, input logic rs, is, iv, input logic [7:0] d, input logic rd,
                   input logic ov, input logic [7:0] od, input logic of, uf, input logic [2:0] cr);
    vec_t e;
    e.nm = nm; e.rs = rs; e.is = is; e.iv = iv; e.d = d; e.rd = rd;
    e.ci = cr != 3'd0; e.ov = ov; e.od = od; e.of = of; e.uf = uf; e.cr = cr;
    q.push_back(e);
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic step(input logic rs, is, iv, input logic [7:0] d, input logic rd);
    rst = rs; issue = is; in_valid = iv; in_data = d; out_ready = rd;
    @(posedge clk);
    #1;
  endtask
  task automatic check_vec(input vec_t e);
    chk({e.nm, ".can_issue"}, 32'(can_issue), 32'(e.ci));
    chk({e.nm, ".out_valid"}, 32'(out_valid), 32'(e.ov));
    if (e.ov) chk({e.nm, ".out_data"}, 32'(out_data), 32'(e.od));
    chk({e.nm, ".overflow"}, 32'(overflow), 32'(e.of));
    chk({e.nm, ".underflow"}, 32'(underflow), 32'(e.uf));
    chk({e.nm, ".credits"}, 32'(dut.r_cred), 32'(e.cr));
  endtask
  initial begin
    total = 0; bad = 0;
    rst = 1'b1; issue = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    v("reset", 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 3'd4);
    v("basic_issue", 0, 1, 0, 8'h00, 1, 0, 8'h00, 0, 0, 3'd3);
    for (int i = 0; i < 4; i++) v("basic_wait", 0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 3'd3);
    v("basic_arrive", 0, 0, 1, 8'hA5, 1, 1, 8'hA5, 0, 0, 3'd3);
    v("basic_pop", 0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 3'd4);
    for (int i = 0; i < 4; i++) v("exhaust", 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 3'(3 - i));
    v("exhaust_5th", 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 3'd0);
    for (int i = 0; i < 5; i++) v("ovf_push", 0, 0, 1, 8'(8'h10 + i), 0, 1, 8'h10, i == 4, 1, 3'd0);
    for (int i = 0; i < 4; i++) v("ovf_pop", 0, 0, 0, 8'h00, 1, i < 3, 8'(8'h11 + i), 1, 1, 3'(i + 1));
    v("pop_empty", 0, 0, 0, 8'h00, 1, 0, 8'h00, 1, 1, 3'd4);
    v("reset2", 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 3'd4);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) v("wrap_push", 0, 1, 1, 8'(8'h01 + 4 * r + i), 0, 1, 8'(8'h01 + 4 * r), 0, 0, 3'(3 - i));
      for (int i = 0; i < 4; i++) v("wrap_pop", 0, 0, 0, 8'h00, 1, i < 3, 8'(8'h02 + 4 * r + i), 0, 0, 3'(i + 1));
    end
    v("sim_fill", 0, 1, 1, 8'h21, 0, 1, 8'h21, 0, 0, 3'd3);
    v("sim_fill", 0, 1, 1, 8'h22, 0, 1, 8'h21, 0, 0, 3'd2);
    v("sim_all", 0, 1, 1, 8'h23, 1, 1, 8'h22, 0, 0, 3'd2);
    v("sim_drain", 0, 0, 0, 8'h00, 1, 1, 8'h23, 0, 0, 3'd3);
    v("sim_drain", 0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 3'd4);
    for (int i = 0; i < 4; i++) v("full_fill", 0, 1, 1, 8'(8'h31 + i), 0, 1, 8'h31, 0, 0, 3'(3 - i));
    v("full_pushpop", 0, 0, 1, 8'h35, 1, 1, 8'h32, 1, 0, 3'd1);
    foreach (q[i]) begin
      step(q[i].rs, q[i].is, q[i].iv, q[i].d, q[i].rd);
      check_vec(q[i]);
    end
    step(1, 0, 1, 8'h36, 0);
    chk("midrst.out_valid", 32'(out_valid), 0);
    chk("midrst.overflow", 32'(overflow), 0);
    chk("midrst.can_issue", 32'(can_issue), 1);
    chk("midrst.credits", 32'(dut.r_cred), 4);
    step(0, 0, 0, 8'h00, 0);
    chk("midrst.dropped", 32'(out_valid), 0);
    chk("midrst.no_ovf", 32'(overflow), 0);
    step(0, 0, 1, 8'h40, 0);
    chk("midrst.fresh_valid", 32'(out_valid), 1);
    chk("midrst.fresh_data", 32'(out_data), 32'h40);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/latency_sink.md
LATENCY_SINK -- requirements
Module: latency_sink

Interface
REQ-001 SHALL have parameter PIPE_WIDTH, default 1: data width of each entry.
REQ-002 SHALL have parameter DEPTH, default 8: buffer entries and initial credit count; a power of 2, minimum 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port issue  input  1  producer launches one entry into the upstream delay line this cycle.
REQ-006 SHALL have port can_issue  output  1  high when at least one credit is available.
REQ-007 SHALL have port in_valid  input  1  delayed entry arriving from the delay line; this input has no backpressure.
REQ-008 SHALL have port in_data  input  PIPE_WIDTH  payload of the arriving entry.
REQ-009 SHALL have port out_valid  output  1  buffer not empty.
REQ-010 SHALL have port out_data  output  PIPE_WIDTH  head entry; valid only while out_valid is high.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the head entry.
REQ-012 SHALL have port overflow  output  1  sticky error flag.
REQ-013 SHALL have port underflow  output  1  sticky error flag.

Function
REQ-014 SHALL keep a credit counter of width $clog2(DEPTH+1).
- Count decrements on accepted issue (issue & can_issue).
- Count increments on a pop (out_valid & out_ready).
- Both in the same cycle: count unchanged.
REQ-015 SHALL drive can_issue = (credits != 0), combinationally from the credit register.
REQ-016 SHALL treat issue while credits == 0 as ignored: credits stay 0 and underflow sets.
REQ-017 SHALL write in_data at the tail pointer on every cycle with in_valid high and the buffer not full.
REQ-018 SHALL use log2(DEPTH)-bit read and write pointers with an extra wrap bit each.
- Pointers wrap from DEPTH-1 to 0.
- Full: indices equal and wrap bits differ.
- Empty: pointers fully equal.
REQ-019 SHALL present the head entry on out_data with zero-cycle read latency (first-word fall-through).
- An entry written in cycle N becomes visible with out_valid high in cycle N+1.
REQ-020 SHALL pop on out_valid & out_ready, advancing the read pointer by one.
REQ-021 SHALL, on in_valid while full, drop in_data, leave the pointers unchanged and set overflow.
- A push and a pop in the same cycle while full is still an overflow: the full check uses registered state.
REQ-022 SHALL, on simultaneous push and pop while not full, advance both pointers and leave occupancy unchanged.
REQ-023 SHALL keep overflow and underflow high until reset once set.
REQ-024 SHALL ignore out_ready while out_valid is low.

Reset
REQ-025 SHALL, when rst is high on a clock edge, set:
- credits to DEPTH
- both pointers to 0
- overflow and underflow to 0
- out_valid low and can_issue high in the following cycle
REQ-026 SHALL discard all buffered entries on reset mid-operation.
- Arrivals during reset are dropped and do not set overflow.
- Entries still in flight in the upstream delay line are the integrator's responsibility: reset both blocks together.
REQ-027 SHALL not require the storage array to be reset; out_data is undefined while out_valid is low.

Configuration
REQ-028 SHALL, when macro LATENCY_SINK_STATS_EN is defined, add statistics outputs:
- hwm_occupancy: $clog2(DEPTH+1) bits, maximum occupancy since reset.
- pop_count: 32 bits, counts pops since reset and wraps at 2^32.
- Both outputs reset to 0.
REQ-029 SHALL, without LATENCY_SINK_STATS_EN, omit these ports and their logic entirely.

Structure
REQ-030 SHALL take the default depth constant and the credit and pointer width functions from the shared package latency_sink_pkg.
REQ-031 SHALL implement the storage array as sub-module sink_ram.
- One write port; one combinational read port.
- Parameters PIPE_WIDTH and DEPTH.
- No reset.
REQ-032 SHALL keep pointers, credits and flags in latency_sink itself.

Verification (DEPTH=4, PIPE_WIDTH=8)
REQ-033 SHALL cover basic flow:
- Stimulus: after reset, issue once; 5 cycles later in_valid with in_data=0xA5; out_ready=1.
- Required: credits 4->3; out_valid high for one cycle with 0xA5; credits back to 4.
REQ-034 SHALL cover credit exhaustion:
- Stimulus: issue 4 times with out_ready=0.
- Required: can_issue low after the 4th issue.
- A 5th issue sets underflow and leaves credits at 0.
REQ-035 SHALL cover full wrap-around:
- Stimulus: push 0x01..0x04, pop all, then push 0x05..0x08 and pop all.
- Required: pops return 0x01..0x08 in order; pointers wrap with no flags set.
REQ-036 SHALL cover overflow:
- Stimulus: push 5 entries 0x10..0x14 with out_ready=0.
- Required: overflow sets on the 5th push; pops then return 0x10..0x13 only.
REQ-037 SHALL cover simultaneous events:
- Stimulus: at occupancy 2 with credits 2, drive issue, push and pop in one cycle.
- Required: occupancy stays 2 and credits stay 2.
REQ-038 SHALL cover reset mid-operation:
- Stimulus: at occupancy 3 with overflow set, assert rst for one cycle.
- Required: out_valid=0, overflow=0, can_issue=1, credits=4.
